// File: rtl/rgbw_spi_master.sv
// rgbw_spi_master: sends one seven-byte RGBW lamp command frame over mode-0 SPI.
module rgbw_spi_master #(
    parameter int SCK_HALF = 4,
    parameter int CS_SETUP = 2,
    parameter int BYTE_GAP = 2,
    parameter int CS_IDLE  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] mode_in,
    input  logic [7:0] colorIdx_in,
    input  logic [7:0] lint_in,
    input  logic [7:0] red_in,
    input  logic [7:0] green_in,
    input  logic [7:0] blue_in,
    input  logic [7:0] white_in,
    output logic       busy,
    output logic       done,
    output logic       sck,
    output logic       mosi,
    output logic       cs
);
    localparam int CW = 16;
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, HOLD, GUARD} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [5:0]    bit_q, bit_d;
    logic [55:0]   sr_q, sr_d;
    logic          cs_q, cs_d, sck_q, sck_d, mosi_q, mosi_d, busy_q, busy_d, done_q, done_d;
    logic          half_end, setup_end, gap_end, idle_end;
    assign cnt_inc   = cnt_q + 1'b1;
    assign half_end  = cnt_q == CW'(SCK_HALF - 1);
    assign setup_end = cnt_q == CW'(CS_SETUP - 1);
    assign gap_end   = cnt_q == CW'(BYTE_GAP - 1);
    assign idle_end  = cnt_q == CW'(CS_IDLE - 1);
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_inc;
        bit_d   = bit_q;
        sr_d    = sr_q;
        cs_d    = cs_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = SETUP;
                    sr_d    = {mode_in, colorIdx_in, lint_in, red_in, green_in, blue_in, white_in};
                    mosi_d  = mode_in[7];
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    bit_d   = '0;
                end
            end
            SETUP: if (setup_end) begin
                state_d = SHIFT;
                cnt_d   = '0;
            end
            SHIFT: if (half_end) begin
                cnt_d = '0;
                sck_d = !sck_q;
                // A falling sck ends the current bit; the last bit's value is held until cs rises
                if (sck_q) begin
                    bit_d = bit_q + 6'd1;
                    if (bit_q == 6'd55) begin
                        state_d = HOLD;
                    end else begin
                        sr_d   = sr_q << 1;
                        mosi_d = sr_q[54];
                        if (bit_q[2:0] == 3'd7 && BYTE_GAP > 0) state_d = GAP;
                    end
                end
            end
            GAP: if (gap_end) begin
                state_d = SHIFT;
                cnt_d   = '0;
            end
            HOLD: if (setup_end) begin
                state_d = GUARD;
                cnt_d   = '0;
                cs_d    = 1'b1;
                mosi_d  = 1'b0;
                done_d  = 1'b1;
            end
            GUARD: if (idle_end) begin
                state_d = IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            cs_q    <= cs_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
    assign busy = busy_q;
    assign done = done_q;
    assign sck  = sck_q;
    assign mosi = mosi_q;
    assign cs   = cs_q;
endmodule

// File: tb/tb_rgbw_spi_master.sv
// tb_rgbw_spi_master: directed frames against hand-computed wire timing and byte content.
module tb_rgbw_spi_master;
    localparam int SCK_HALF = 4;
    localparam int CS_SETUP = 2;
    localparam int BYTE_GAP = 2;
    localparam int CS_IDLE  = 4;
    logic clk, reset, start;
    logic [7:0] mode_in, colorIdx_in, lint_in, red_in, green_in, blue_in, white_in;
    logic busy, done, sck, mosi, cs;
    logic [55:0] exp_frame;
    logic [55:0] cap;
    int n_vec, n_err;
    int rises, first_rise, last_fall, cs_low, rise_off, done_cnt, done_off, busy_off;
    int gap_bad, mosi_bad, sck_cs_bad;

    rgbw_spi_master #(
        .SCK_HALF(SCK_HALF), .CS_SETUP(CS_SETUP), .BYTE_GAP(BYTE_GAP), .CS_IDLE(CS_IDLE)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .mode_in(mode_in), .colorIdx_in(colorIdx_in), .lint_in(lint_in), .red_in(red_in),
        .green_in(green_in), .blue_in(blue_in), .white_in(white_in),
        .busy(busy), .done(done), .sck(sck), .mosi(mosi), .cs(cs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [55:0] f);
        {mode_in, colorIdx_in, lint_in, red_in, green_in, blue_in, white_in} = f;
    endtask

    task automatic kick();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Observes one frame from the accepting edge (offset 0) until busy drops.
    task automatic watch(input int budget, input int abort_at, input bit mutate, input bit repulse);
        logic psck, pmosi, pcs;
        psck = 1'b0; pmosi = 1'b0; pcs = 1'b1;
        cap = '0; rises = 0; first_rise = -1; last_fall = -1; cs_low = 0; rise_off = -1;
        done_cnt = 0; done_off = -1; busy_off = -1; gap_bad = 0; mosi_bad = 0; sck_cs_bad = 0;
        if (mutate) load('0);
        for (int off = 0; off <= budget; off++) begin
            if (off > 0) begin
                @(posedge clk);
                #1;
            end
            if (repulse) start = (off == 9 || off == 465);
            if (sck && !psck) begin
                rises++;
                if (rises == 1) first_rise = off;
                cap = {cap[54:0], mosi};
                if (cs) sck_cs_bad++;
                if (rises > 1 && (rises - 1) % 8 == 0 && off - last_fall != SCK_HALF + BYTE_GAP) gap_bad++;
            end
            if (!sck && psck) begin
                last_fall = off;
                if (cs) sck_cs_bad++;
            end
            if (mosi != pmosi && !(!sck && psck) && cs == pcs) mosi_bad++;
            if (!cs) cs_low++;
            if (cs && !pcs) rise_off = off;
            if (done) begin
                done_cnt++;
                done_off = off;
            end
            psck = sck; pmosi = mosi; pcs = cs;
            if (!busy) begin
                busy_off = off;
                break;
            end
            if (off == abort_at) break;
        end
    endtask

    task automatic check_frame(input string p);
        chk({p, "_bytes"}, longint'(cap), longint'(exp_frame));
        chk({p, "_rises"}, rises, 56);
        chk({p, "_first_rise"}, first_rise, CS_SETUP + SCK_HALF);
        chk({p, "_last_fall"}, last_fall, CS_SETUP + 112 * SCK_HALF + 6 * BYTE_GAP);
        chk({p, "_cs_low"}, cs_low, 464);
        chk({p, "_cs_rise"}, rise_off, 464);
        chk({p, "_done_at"}, done_off, 464);
        chk({p, "_done_len"}, done_cnt, 1);
        chk({p, "_busy_fall"}, busy_off, 468);
        chk({p, "_byte_gap"}, gap_bad, 0);
        chk({p, "_mosi_stable"}, mosi_bad, 0);
        chk({p, "_sck_cs_high"}, sck_cs_bad, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        int lows, k;
        n_vec = 0; n_err = 0;
        exp_frame = 56'h01_22_80_FF_00_A5_5A;
        reset = 1'b0; start = 1'b0;
        load(exp_frame);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {cs, sck, mosi, busy, done}, 5'b10000);
        @(negedge clk);
        reset = 1'b1;

        // Single frame with payload changes and ignored re-pulses mid-frame.
        kick();
        start = 1'b0;
        chk("e0_state", {cs, busy, mosi}, {1'b0, 1'b1, exp_frame[55]});
        watch(600, -1, 1'b1, 1'b1);
        check_frame("single");
        lows = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (!cs || busy) lows++;
        end
        chk("no_requeue", lows, 0);

        // start held high: three identical back-to-back frames.
        load(exp_frame);
        kick();
        for (int f = 0; f < 3; f++) begin
            chk("b2b_e0", {cs, busy, mosi}, {1'b0, 1'b1, exp_frame[55]});
            if (f == 2) start = 1'b0;
            watch(600, -1, 1'b0, 1'b0);
            check_frame("b2b");
            if (f < 2) begin
                for (k = 0; k < 20 && (k == 0 || cs); k++) begin
                    @(posedge clk);
                    #1;
                end
                chk("b2b_cs_idle", busy_off + k - rise_off - 1, CS_IDLE);
            end
        end
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (!cs) lows++;
        end
        chk("b2b_stops", lows, 0);

        // Asynchronous reset mid-frame, then a clean frame.
        kick();
        start = 1'b0;
        watch(600, 200, 1'b0, 1'b0);
        chk("pre_reset_cs", cs, 0);
        #3;
        reset = 1'b0;
        #1;
        chk("async_reset", {cs, sck, mosi, busy, done}, 5'b10000);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        kick();
        start = 1'b0;
        chk("post_rst_e0", {cs, busy, mosi}, {1'b0, 1'b1, exp_frame[55]});
        watch(600, -1, 1'b0, 1'b0);
        check_frame("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
